// File: rtl/square_object_mover.sv
// rtl/square_object_mover.sv - bouncing rectangle with collision flash and registered pixel hit test
module square_object_mover #(
  parameter int          OBJ_W        = 32,
  parameter int          OBJ_H        = 32,
  parameter int          SCREEN_W     = 640,
  parameter int          SCREEN_H     = 480,
  parameter int          INIT_X       = 100,
  parameter int          INIT_Y       = 100,
  parameter int          SPEED_X      = 2,
  parameter int          SPEED_Y      = 1,
  parameter logic [11:0] OBJ_COLOR    = 12'hF00,
  parameter logic [11:0] FLASH_COLOR  = 12'hFFF,
  parameter int          FLASH_FRAMES = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        collision,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic        drawingRequest,
  output logic [11:0] RGB_out,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY
);

  typedef enum logic {MOVE = 1'b0, FLASH = 1'b1} state_t;

  localparam logic [10:0]        LP_X0    = 11'(INIT_X);
  localparam logic [10:0]        LP_Y0    = 11'(INIT_Y);
  localparam logic signed [11:0] LP_VX0   = 12'(SPEED_X);
  localparam logic signed [11:0] LP_VY0   = 12'(SPEED_Y);
  localparam logic signed [11:0] LP_X_MAX = 12'(SCREEN_W - OBJ_W);
  localparam logic signed [11:0] LP_Y_MAX = 12'(SCREEN_H - OBJ_H);
  localparam logic [11:0]        LP_W     = 12'(OBJ_W);
  localparam logic [11:0]        LP_H     = 12'(OBJ_H);
  localparam logic [7:0]         LP_CNT0  = 8'(FLASH_FRAMES - 1);

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_cnt, w_cnt_nxt;
  logic               r_pend;
  logic               w_pend_eff, w_tick, w_neg;
  logic [10:0]        r_x, r_y, w_x_nxt, w_y_nxt;
  logic signed [11:0] r_vx, r_vy, w_vx_pre, w_vy_pre, w_vx_nxt, w_vy_nxt;
  logic               r_draw;
  logic [11:0]        r_rgb;
  logic               w_inside;
  logic [11:0]        w_color;

  // One axis step: move by vel, then clamp to [0, lim] forcing the velocity sign away from the wall.
  function automatic logic [22:0] axis_step(input logic [10:0] pos, input logic signed [11:0] vel,
                                            input logic signed [11:0] lim);
    logic signed [11:0] w_n, w_mag;
    w_n   = $signed({1'b0, pos}) + vel;
    w_mag = vel[11] ? -vel : vel;
    if (w_n < 0)
      return {11'd0, w_mag};
    else if (w_n > lim)
      return {lim[10:0], -w_mag};
    else
      return {w_n[10:0], vel};
  endfunction

  assign w_tick     = startOfFrame & enable;
  assign w_pend_eff = r_pend | collision;

  // Next-state: collision handling and flash timing at each enabled frame tick, then motion with bounce.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_neg       = 1'b0;
    if (w_tick) begin
      case (r_state)
        MOVE: begin
          if (w_pend_eff) begin
            w_neg       = 1'b1;
            w_state_nxt = FLASH;
            w_cnt_nxt   = LP_CNT0;
          end
        end
        FLASH: begin
          if (r_cnt == 8'd0)
            w_state_nxt = MOVE;
          else
            w_cnt_nxt = r_cnt - 8'd1;
        end
        default: w_state_nxt = MOVE;
      endcase
    end
    w_vx_pre = w_neg ? -r_vx : r_vx;
    w_vy_pre = w_neg ? -r_vy : r_vy;
    {w_x_nxt, w_vx_nxt} = axis_step(r_x, w_vx_pre, LP_X_MAX);
    {w_y_nxt, w_vy_nxt} = axis_step(r_y, w_vy_pre, LP_Y_MAX);
  end

  // State, counter, pending flag and motion registers; motion only changes on an enabled frame tick.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state <= MOVE;
      r_cnt   <= 8'd0;
      r_pend  <= 1'b0;
      r_x     <= LP_X0;
      r_y     <= LP_Y0;
      r_vx    <= LP_VX0;
      r_vy    <= LP_VY0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_tick ? 1'b0 : w_pend_eff;
      if (w_tick) begin
        r_x  <= w_x_nxt;
        r_y  <= w_y_nxt;
        r_vx <= w_vx_nxt;
        r_vy <= w_vy_nxt;
      end
    end
  end

  assign w_inside = ({1'b0, pixelX} >= {1'b0, r_x}) && ({1'b0, pixelX} < ({1'b0, r_x} + LP_W)) &&
                    ({1'b0, pixelY} >= {1'b0, r_y}) && ({1'b0, pixelY} < ({1'b0, r_y} + LP_H));
  assign w_color  = ((r_state == FLASH) && r_cnt[1]) ? FLASH_COLOR : OBJ_COLOR;

  // Registered hit test and colour, one cycle behind the scan coordinates.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_draw <= 1'b0;
      r_rgb  <= 12'h000;
    end else begin
      r_draw <= w_inside;
      r_rgb  <= w_inside ? w_color : 12'h000;
    end
  end

  assign drawingRequest = r_draw;
  assign RGB_out        = r_rgb;
  assign topLeftX       = r_x;
  assign topLeftY       = r_y;

endmodule
